// File: rtl/shift_pkg.sv
// Shared constants for the multicycle shift sequencer: state encoding,
// shift-type codes and the per-stage shift amounts (index k -> 2^k).
package shift_pkg;

  localparam int WIDTH   = 32;
  localparam int NSTAGES = 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRA = 2'b01;
  localparam logic [1:0] SHIFT_SRL = 2'b10;

  // Element k holds 2^k, so the list reads in execution order 16,8,4,2,1.
  localparam logic [4:0] STAGE_AMT [NSTAGES-1:0] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

  // True when no shamt bit below stage index k is set.
  function automatic logic low_bits_clear(input logic [NSTAGES-1:0] shamt,
                                          input logic [2:0] k);
    low_bits_clear = 1'b1;
    for (int i = 0; i < NSTAGES; i++) begin
      if ((i < int'(k)) && shamt[i]) low_bits_clear = 1'b0;
    end
  endfunction

endpackage

// File: rtl/shift_stage_mux.sv
// Combinational selector: builds the fixed-amount SLL/SRL/SRA stages and
// returns the one for the current stage index k and shift kind.
module shift_stage_mux
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] work,
  input  logic [2:0]       k,
  input  logic [1:0]       shift_type,
  output logic [WIDTH-1:0] stage_out
);

  logic [WIDTH-1:0] sll_s [NSTAGES];
  logic [WIDTH-1:0] srl_s [NSTAGES];
  logic [WIDTH-1:0] sra_s [NSTAGES];

  for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
    assign sll_s[g] = work << STAGE_AMT[g];
    assign srl_s[g] = work >> STAGE_AMT[g];
    assign sra_s[g] = $signed(work) >>> STAGE_AMT[g];
  end

  // Reserved type 2'b11 falls through to SLL.
  always_comb begin
    stage_out = work;
    if (k < 3'(NSTAGES)) begin
      case (shift_type)
        SHIFT_SRA: stage_out = sra_s[k];
        SHIFT_SRL: stage_out = srl_s[k];
        default:   stage_out = sll_s[k];
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle 32-bit shifter: one barrel stage (16,8,4,2,1) per clock.
// Define SHIFT_SEQ_EARLY_EXIT_EN to finish at the lowest set shamt bit.
module shift_sequencer
  import shift_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_shift,
  input  logic [1:0]       ctrl_type,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [4:0]       ctrl_shamt,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a start is taken on any edge where ctrl_shift=1 and the
  // unit is ready (IDLE or DONE); data_resultRDY is a one-cycle pulse
  // while in DONE, and busy covers exactly the SHIFT cycles.
  logic [1:0]       state, state_next;
  logic [2:0]       k;
  logic [4:0]       shamt_q;
  logic [1:0]       type_q;
  logic [WIDTH-1:0] work, work_next, stage_out;
  logic             ready, accept, last_stage;

  shift_stage_mux u_stage_mux (
    .work       (work),
    .k          (k),
    .shift_type (type_q),
    .stage_out  (stage_out)
  );

  assign ready     = (state == IDLE) || (state == DONE);
  assign accept    = ready && ctrl_shift;
  assign work_next = shamt_q[k] ? stage_out : work;

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  assign last_stage = low_bits_clear(shamt_q, k);
`else
  assign last_stage = (k == 3'd0);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_shift) state_next = SHIFT;
      SHIFT:   if (last_stage) state_next = DONE;
      DONE:    state_next = ctrl_shift ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_resultRDY = (state == DONE);
    busy           = (state == SHIFT);
    dbg_state      = state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work        <= '0;
      shamt_q     <= '0;
      type_q      <= '0;
      k           <= '0;
      data_result <= '0;
    end else if (accept) begin
      work    <= data_operandA;
      shamt_q <= ctrl_shamt;
      type_q  <= ctrl_type;
      k       <= 3'(NSTAGES - 1);
    end else if (state == SHIFT) begin
      work <= work_next;
      if (last_stage) data_result <= work_next;
      else            k <= k - 3'd1;
    end
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle 32-bit shift unit; drives one barrel-shift stage per clock: 16, 8, 4, 2, 1.
- Sits between the decode/execute control and the fixed-amount shift stages; consumes the per-stage outputs.
- Returns the result to the execute-stage writeback mux using the processor's start/result-ready handshake.
- Trades latency for area versus the single-cycle barrel shifter.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported (stage amounts are fixed at 16/8/4/2/1).
- NSTAGES, 5, number of shift stages; equals the shamt width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- ctrl_shift  input  1  start pulse; sampled only when ready.
- ctrl_type  input  2  shift kind: 00 SLL, 01 SRA, 10 SRL, 11 reserved (executes as SLL).
- data_operandA  input  32  value to shift.
- ctrl_shamt  input  5  shift amount 0..31.
- data_result  output  32  shifted value; held until the next accepted start.
- data_resultRDY  output  1  one-cycle pulse when data_result becomes valid.
- busy  output  1  high from the accepting edge until the edge that raises data_resultRDY.

Behaviour:
- Reset values: data_result=0, data_resultRDY=0, busy=0, state=IDLE. Latched operand, shamt and type are cleared to 0.
- States: IDLE, SHIFT, DONE. Internal 3-bit stage index k counts 4 down to 0.
- Ready means state is IDLE or DONE.
- Accept (edge E0, ready and ctrl_shift=1):
  - Latch data_operandA into the work register, and latch ctrl_shamt and ctrl_type.
  - Set k=4, go to SHIFT, busy=1.
- SHIFT, edges E1..E5: at edge Ei the work register takes the stage-(2^k) shift if shamt[k]=1, otherwise it holds. Then k decrements.
- Per-stage fill rules:
  - SLL: shift left, vacated low bits filled with 0.
  - SRL: shift right, vacated high bits filled with 0.
  - SRA: shift right, vacated high bits filled with work[31] (the current sign bit, which equals the original sign).
- At the edge that processes k=0:
  - data_result takes the final value.
  - Go to DONE; data_resultRDY=1 and busy=0 for exactly the following cycle.
- Latency: result visible 5 cycles after the accepting edge (the cycle after E5).
- DONE leaves at the next edge:
  - to SHIFT if ctrl_shift=1 (back-to-back accept; data_resultRDY drops);
  - otherwise to IDLE.
- ctrl_shift during SHIFT is ignored; it is neither queued nor an error.
- Input changes after acceptance have no effect.
- data_result changes only at the final SHIFT edge. It is never exposed mid-computation.
- shamt=0: still runs the 5 cycles; result equals the operand.
- shamt=31 (SLL): result is operand[0] followed by 31 zeros.
- Reset asserted mid-operation: immediate return to reset values. No data_resultRDY pulse, and the operation is lost.

Optional Feature:
- SHIFT_SEQ_EARLY_EXIT_EN, when defined:
  - SHIFT finishes at the edge processing the lowest set bit of the latched shamt. Once all remaining shamt bits below k are 0, that edge also loads data_result and goes to DONE.
  - Latency = 5 − (index of the lowest set shamt bit) cycles.
  - shamt=0 finishes at E1 with the unmodified operand (latency 1).
- When undefined: fixed 5-cycle latency for every shamt.

Decomposition:
- Shared package shift_pkg:
  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - ctrl_type codes SHIFT_SLL/SHIFT_SRA/SHIFT_SRL;
  - STAGE_AMT constant {16,8,4,2,1}.
- One natural sub-module: shift_stage_mux, a combinational selector. It picks the SLL/SRL/SRA result for the current k from the existing fixed-amount stage blocks.
- The FSM, stage counter and work register stay in shift_sequencer.

Test Plan:
- Reset, then SLL of 0x0000_0001 by 16 (shift applied at E1) -> data_result=0x0001_0000, data_resultRDY pulse in the cycle after E5, busy high for E0..E5.
- SRA of 0x8000_0000 by 31 -> 0xFFFF_FFFF; SRL of the same operand by 31 -> 0x0000_0001.
- SLL of 0x1234_5678 by 0 -> 0x1234_5678 after 5 cycles; with SHIFT_SEQ_EARLY_EXIT_EN -> after 1 cycle. With early exit, shamt=4 -> latency 3.
- ctrl_shift pulsed during SHIFT with a different operand -> ignored; first result is unchanged. ctrl_shift held high in the DONE cycle -> second op accepted back-to-back, second result 5 cycles later.
- reset driven low at E3 of an SRL 0xF000_000F by 7 -> outputs 0 immediately, no data_resultRDY. The next op after release completes correctly.
- ctrl_type=11 with 0x0000_00FF by 8 -> 0x0000_FF00 (executes as SLL).
